// File: rtl/mips_pkg.sv
// Shared widths and response-owner encoding for the MIPS unified-memory arbiter.
// Pure declarations: no latency, no backpressure.
package mips_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int RUN_W  = 4;  // holds MAX_D_RUN up to 15

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mips_arb_prio.sv
// Fetch/data priority pick with starvation override; purely combinational.
// Data wins unless fetch has waited through MAX_D_RUN data grants.
module mips_arb_prio #(
  parameter int MAX_D_RUN = 4
) (
  input  logic                      if_req_i,
  input  logic                      d_req_i,
  input  logic [mips_pkg::RUN_W-1:0] run_cnt_i,
  output logic                      if_gnt_o,
  output logic                      d_gnt_o
);

  logic starved;

  assign starved  = run_cnt_i >= mips_pkg::RUN_W'(MAX_D_RUN);
  assign d_gnt_o  = d_req_i & ~(if_req_i & starved);
  assign if_gnt_o = if_req_i & ~d_gnt_o;

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port memory between fetch and load/store; grant same cycle, read data next cycle.
// Losing requester holds its request; a fetch is forced through after MAX_D_RUN data grants.
module mips_mem_arbiter #(
  parameter int ADDR_W    = mips_pkg::ADDR_W,
  parameter int DATA_W    = mips_pkg::DATA_W,
  parameter int MAX_D_RUN = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import mips_pkg::*;

  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  owner_e            owner_q, owner_d;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              arb_if_gnt, arb_d_gnt;

  mips_arb_prio #(
    .MAX_D_RUN (MAX_D_RUN)
  ) u_prio (
    .if_req_i  (if_req),
    .d_req_i   (d_req),
    .run_cnt_i (run_cnt_q),
    .if_gnt_o  (arb_if_gnt),
    .d_gnt_o   (arb_d_gnt)
  );

  // Reset is synchronous, but outputs must read as idle during the reset cycle itself.
  assign if_gnt = arb_if_gnt & ~rst;
  assign d_gnt  = arb_d_gnt & ~rst;

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  always_comb begin
    run_cnt_d = run_cnt_q;
    owner_d   = OWN_NONE;
    if (if_gnt || !if_req) begin
      run_cnt_d = '0;
    end else if (d_gnt && run_cnt_q < RUN_W'(MAX_D_RUN)) begin
      run_cnt_d = run_cnt_q + RUN_W'(1);
    end
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_D;
    end
  end

  // Flush kills only the fetch already in flight; the memory read still happens.
  assign if_rvalid = ~rst & (owner_q == OWN_IF) & ~if_flush;
  assign d_rvalid  = ~rst & (owner_q == OWN_D);
  assign if_rdata  = rst ? '0 : (if_rvalid ? mem_rdata : if_rdata_q);
  assign d_rdata   = rst ? '0 : (d_rvalid ? mem_rdata : d_rdata_q);

  always_ff @(posedge clk1) begin
    if (rst) begin
      run_cnt_q  <= '0;
      owner_q    <= OWN_NONE;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
      owner_q   <= owner_d;
      if (if_rvalid) if_rdata_q <= mem_rdata;
      if (d_rvalid)  d_rdata_q  <= mem_rdata;
    end
  end

  a_if_hold: assert property (@(posedge clk1)
    (!rst && if_req && !if_gnt) |=> (if_req && $stable(if_addr)));
  a_d_hold: assert property (@(posedge clk1)
    (!rst && d_req && !d_gnt) |=> (d_req && $stable(d_we) && $stable(d_addr) && $stable(d_wdata)));

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a backing memory, a cycle model and literal spot checks.
module tb_mips_mem_arbiter;

  localparam int AW   = 9;
  localparam int DW   = 32;
  localparam int MAXR = 4;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int errs   = 0;
  int checks = 0;

  always #5 clk1 = ~clk1;

  mips_mem_arbiter dut (
    .clk1(clk1), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return (a == 'h40) ? 32'hDEADBEEF : 32'h1000 + DW'(a);
  endfunction

  // Backing memory: one access per cycle, read data one cycle later; reloaded while in reset.
  logic [DW-1:0] mem [0:511];
  always @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected outputs from the arbitration rules plus a shadow memory.
  logic [DW-1:0] ref_mem [0:511];
  int            streak;
  bit            p_if, p_d;
  logic [DW-1:0] p_if_dat, p_d_dat, last_if, last_d;

  always @(negedge clk1) begin
    bit            e_d, e_i, e_ifv, e_dv;
    logic [DW-1:0] e_ifd, e_dd, e_wd;
    logic [AW-1:0] e_addr;
    if (rst) begin
      chk("mdl_rst_if_gnt", 32'(if_gnt), 0);
      chk("mdl_rst_d_gnt", 32'(d_gnt), 0);
      chk("mdl_rst_if_rvalid", 32'(if_rvalid), 0);
      chk("mdl_rst_d_rvalid", 32'(d_rvalid), 0);
      chk("mdl_rst_mem_en", 32'(mem_en), 0);
      chk("mdl_rst_mem_we", 32'(mem_we), 0);
      chk("mdl_rst_if_rdata", if_rdata, 0);
      chk("mdl_rst_d_rdata", d_rdata, 0);
      for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
      streak = 0; p_if = 0; p_d = 0; last_if = '0; last_d = '0;
    end else begin
      e_d    = d_req && !(if_req && streak >= MAXR);
      e_i    = if_req && !e_d;
      e_ifv  = p_if && !if_flush;
      e_dv   = p_d;
      e_ifd  = e_ifv ? p_if_dat : last_if;
      e_dd   = e_dv ? p_d_dat : last_d;
      e_addr = e_d ? d_addr : (e_i ? if_addr : '0);
      e_wd   = e_d ? d_wdata : '0;
      chk("mdl_if_gnt", 32'(if_gnt), 32'(e_i));
      chk("mdl_d_gnt", 32'(d_gnt), 32'(e_d));
      chk("mdl_if_rvalid", 32'(if_rvalid), 32'(e_ifv));
      chk("mdl_d_rvalid", 32'(d_rvalid), 32'(e_dv));
      chk("mdl_if_rdata", if_rdata, e_ifd);
      chk("mdl_d_rdata", d_rdata, e_dd);
      chk("mdl_mem_en", 32'(mem_en), 32'(e_i || e_d));
      chk("mdl_mem_we", 32'(mem_we), 32'(e_d && d_we));
      chk("mdl_mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mdl_mem_wdata", mem_wdata, e_wd);
      last_if  = e_ifd;
      last_d   = e_dd;
      p_if     = e_i;
      p_if_dat = ref_mem[if_addr];
      p_d      = e_d && !d_we;
      p_d_dat  = ref_mem[d_addr];
      if (e_d && d_we) ref_mem[d_addr] = d_wdata;
      if (e_i || !if_req) streak = 0;
      else if (e_d && streak < MAXR) streak = streak + 1;
    end
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req = 0; if_addr = '0; if_flush = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    step();
    #3;
    chk("reset_mem_en", 32'(mem_en), 0);
    chk("reset_d_rvalid", 32'(d_rvalid), 0);
    step();
    rst = 1'b0;

    // Fetch stream 0..3
    for (int a = 0; a < 5; a++) begin
      if_req  = (a < 4);
      if_addr = AW'(a);
      #3;
      if (a < 4) chk("t1_if_gnt", 32'(if_gnt), 1);
      if (a > 0) begin
        chk("t1_if_rvalid", 32'(if_rvalid), 1);
        chk("t1_if_rdata", if_rdata, 32'h1000 + 32'(a - 1));
      end
      step();
    end

    // Lone load
    d_req = 1; d_we = 0; d_addr = 9'h40;
    #3;
    chk("t2_d_gnt", 32'(d_gnt), 1);
    chk("t2_mem_addr", 32'(mem_addr), 32'h40);
    step();
    d_req = 0;
    #3;
    chk("t2_d_rvalid", 32'(d_rvalid), 1);
    chk("t2_d_rdata", d_rdata, 32'hDEADBEEF);
    step();

    // Both held: D,D,D,D,IF repeating
    if_req = 1; if_addr = 9'd5; d_req = 1; d_we = 0; d_addr = 9'd6;
    for (int i = 0; i < 10; i++) begin
      #3;
      chk("t3_d_gnt", 32'(d_gnt), 32'(i % 5 != 4));
      chk("t3_if_gnt", 32'(if_gnt), 32'(i % 5 == 4));
      step();
    end
    if_req = 0;
    #3;
    chk("t3_d_gnt_tail", 32'(d_gnt), 1);
    step();
    d_req = 0;
    step();

    // Store then load same address
    d_req = 1; d_we = 1; d_addr = 9'h80; d_wdata = 32'h12345678;
    #3;
    chk("t4_st_gnt", 32'(d_gnt), 1);
    chk("t4_mem_we", 32'(mem_we), 1);
    chk("t4_mem_wdata", mem_wdata, 32'h12345678);
    step();
    d_we = 0;
    #3;
    chk("t4_no_rvalid_after_store", 32'(d_rvalid), 0);
    chk("t4_ld_gnt", 32'(d_gnt), 1);
    step();
    d_req = 0;
    #3;
    chk("t4_ld_rvalid", 32'(d_rvalid), 1);
    chk("t4_ld_rdata", d_rdata, 32'h12345678);
    step();

    // Flush of an in-flight fetch, new fetch in the same cycle
    if_req = 1; if_addr = 9'd7;
    #3;
    chk("t5_if_gnt0", 32'(if_gnt), 1);
    step();
    if_flush = 1; if_addr = 9'd8;
    #3;
    chk("t5_flushed_rvalid", 32'(if_rvalid), 0);
    chk("t5_if_gnt1", 32'(if_gnt), 1);
    step();
    if_flush = 0; if_req = 0;
    #3;
    chk("t5_rvalid", 32'(if_rvalid), 1);
    chk("t5_rdata", if_rdata, 32'h1008);
    step();

    // Reset mid-operation with a load in flight and a partial data run
    if_req = 1; if_addr = 9'd9; d_req = 1; d_we = 0; d_addr = 9'h40;
    #3;
    chk("t6_d_gnt0", 32'(d_gnt), 1);
    step();
    #3;
    chk("t6_d_gnt1", 32'(d_gnt), 1);
    step();
    rst = 1;
    #3;
    chk("t6_rst_d_rvalid", 32'(d_rvalid), 0);
    chk("t6_rst_d_rdata", d_rdata, 0);
    chk("t6_rst_if_gnt", 32'(if_gnt), 0);
    step();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("t6_d_gnt", 32'(d_gnt), 32'(i < 4));
      chk("t6_if_gnt", 32'(if_gnt), 32'(i == 4));
      if (i == 0) chk("t6_dropped_rvalid", 32'(d_rvalid), 0);
      step();
    end
    if_req = 0;
    #3;
    chk("t6_d_gnt_tail", 32'(d_gnt), 1);
    step();
    d_req = 0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
